// File: rtl/lamp_pkg.sv
// Shared lamp codes, phase and state encodings for the lamp sequence checker.
package lamp_pkg;

  localparam logic [2:0] LAMP_P0 = 3'b100;
  localparam logic [2:0] LAMP_P1 = 3'b010;
  localparam logic [2:0] LAMP_P2 = 3'b001;

  typedef logic [1:0] phase_t;
  localparam phase_t PHASE_P0   = 2'd0;
  localparam phase_t PHASE_P1   = 2'd1;
  localparam phase_t PHASE_P2   = 2'd2;
  localparam phase_t PHASE_NONE = 2'd3;

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED, FAULT} state_t;

  function automatic logic [2:0] phase_code(input phase_t p);
    case (p)
      PHASE_P0: phase_code = LAMP_P0;
      PHASE_P1: phase_code = LAMP_P1;
      PHASE_P2: phase_code = LAMP_P2;
      default:  phase_code = 3'b000;
    endcase
  endfunction

  function automatic phase_t code_phase(input logic [2:0] c);
    case (c)
      LAMP_P0: code_phase = PHASE_P0;
      LAMP_P1: code_phase = PHASE_P1;
      LAMP_P2: code_phase = PHASE_P2;
      default: code_phase = PHASE_NONE;
    endcase
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    next_phase = (p == PHASE_P2) ? PHASE_P0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/lamp_sequence_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones, cleared only by synchronous reset.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lamp_sequence_checker.sv
// Locks onto the 100->010->001 lamp rotation (each code held DWELL clocks),
// flags departures while locked and counts faults and completed rotations.
module lamp_sequence_checker
  import lamp_pkg::*;
#(
  parameter int DWELL    = 1,
  parameter int LOCK_LEN = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam int MW   = $clog2(LOCK_LEN + 1);

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [MW-1:0]   match_q, match_d;

  logic            exp_adv, seq_ok, err_inc, cyc_inc;
  phase_t          exp_phase, light_phase;
  logic [DW_W-1:0] dwell_adv;
  logic [MW-1:0]   match_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      phase_q <= PHASE_NONE;
      dwell_q <= '0;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      match_q <= match_d;
    end
  end

  // Expected code: hold the current phase until DWELL samples seen, then the next one.
  always_comb begin
    exp_adv     = (dwell_q >= DW_W'(DWELL));
    exp_phase   = exp_adv ? next_phase(phase_q) : phase_q;
    seq_ok      = (light == phase_code(exp_phase));
    light_phase = code_phase(light);
    dwell_adv   = exp_adv ? DW_W'(1) : dwell_q + DW_W'(1);
    match_inc   = match_q + MW'(1);

    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    match_d = match_q;
    err_inc = 1'b0;
    cyc_inc = 1'b0;

    case (state_q)
      HUNT: begin
        if (light_phase != PHASE_NONE) begin
          phase_d = light_phase;
          dwell_d = DW_W'(1);
          match_d = MW'(1);
          state_d = (LOCK_LEN == 1) ? LOCKED : TRACK;
        end else begin
          phase_d = PHASE_NONE;
        end
      end
      TRACK: begin
        if (seq_ok) begin
          phase_d = exp_phase;
          dwell_d = dwell_adv;
          match_d = match_inc;
          if (match_inc == MW'(LOCK_LEN)) state_d = LOCKED;
        end else begin
          state_d = HUNT;
          phase_d = PHASE_NONE;
          dwell_d = '0;
          match_d = '0;
        end
      end
      LOCKED: begin
        if (seq_ok) begin
          phase_d = exp_phase;
          dwell_d = dwell_adv;
          cyc_inc = exp_adv && (phase_q == PHASE_P2);
        end else begin
          state_d = FAULT;
          phase_d = PHASE_NONE;
          err_inc = 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
        phase_d = PHASE_NONE;
        dwell_d = '0;
        match_d = '0;
      end
    endcase
  end

  always_comb begin
    locked = (state_q == LOCKED);
    fault  = (state_q == FAULT);
    phase  = phase_q;
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cyc_inc),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_lamp_sequence_checker.sv
// Directed bench: three checker instances (DWELL=1/CNT_W=8, CNT_W=2, DWELL=2).
module tb_lamp_sequence_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] l1 = 3'b000, l2 = 3'b000, l3 = 3'b000;

  logic       lk1, f1, lk2, f2, lk3, f3;
  logic [1:0] ph1, ph2, ph3;
  logic [7:0] e1, c1, e3, c3;
  logic [1:0] e2, c2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lamp_sequence_checker #(.DWELL(1), .LOCK_LEN(3), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .light(l1), .locked(lk1), .fault(f1),
    .phase(ph1), .err_count(e1), .cycle_count(c1));

  lamp_sequence_checker #(.DWELL(1), .LOCK_LEN(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .light(l2), .locked(lk2), .fault(f2),
    .phase(ph2), .err_count(e2), .cycle_count(c2));

  lamp_sequence_checker #(.DWELL(2), .LOCK_LEN(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .light(l3), .locked(lk3), .fault(f3),
    .phase(ph3), .err_count(e3), .cycle_count(c3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int inst,
                         input logic [31:0] lk, input logic [31:0] f, input logic [31:0] ph,
                         input logic [31:0] e, input logic [31:0] c);
    case (inst)
      1: begin
        chk({tag, ".locked"}, {31'd0, lk1}, lk); chk({tag, ".fault"}, {31'd0, f1}, f);
        chk({tag, ".phase"}, {30'd0, ph1}, ph); chk({tag, ".err"}, {24'd0, e1}, e);
        chk({tag, ".cyc"}, {24'd0, c1}, c);
      end
      2: begin
        chk({tag, ".locked"}, {31'd0, lk2}, lk); chk({tag, ".fault"}, {31'd0, f2}, f);
        chk({tag, ".phase"}, {30'd0, ph2}, ph); chk({tag, ".err"}, {30'd0, e2}, e);
        chk({tag, ".cyc"}, {30'd0, c2}, c);
      end
      default: begin
        chk({tag, ".locked"}, {31'd0, lk3}, lk); chk({tag, ".fault"}, {31'd0, f3}, f);
        chk({tag, ".phase"}, {30'd0, ph3}, ph); chk({tag, ".err"}, {24'd0, e3}, e);
        chk({tag, ".cyc"}, {24'd0, c3}, c);
      end
    endcase
  endtask

  task automatic s1(input string tag, input logic [2:0] v, input int lk, input int f,
                    input int ph, input int e, input int c);
    l1 = v; tick(); chk_all(tag, 1, lk, f, ph, e, c);
  endtask

  task automatic s2(input string tag, input logic [2:0] v, input int lk, input int f,
                    input int ph, input int e, input int c);
    l2 = v; tick(); chk_all(tag, 2, lk, f, ph, e, c);
  endtask

  task automatic s3(input string tag, input logic [2:0] v, input int lk, input int f,
                    input int ph, input int e, input int c);
    l3 = v; tick(); chk_all(tag, 3, lk, f, ph, e, c);
  endtask

  initial begin
    // Reset and idle with invalid code
    rst = 1'b1; tick(); rst = 1'b0;
    chk_all("rst1", 1, 0, 0, 3, 0, 0);
    chk_all("rst2", 2, 0, 0, 3, 0, 0);
    chk_all("rst3", 3, 0, 0, 3, 0, 0);
    for (int i = 0; i < 5; i++) s1("idle", 3'b000, 0, 0, 3, 0, 0);

    // Lock timing, tracking, fault and relock
    s1("cap_p0",  3'b100, 0, 0, 0, 0, 0);
    s1("trk_p1",  3'b010, 0, 0, 1, 0, 0);
    s1("lock_p2", 3'b001, 1, 0, 2, 0, 0);
    s1("wrap",    3'b100, 1, 0, 0, 0, 1);
    s1("lk_p1",   3'b010, 1, 0, 1, 0, 1);
    s1("fault",   3'b100, 0, 1, 3, 1, 1);
    s1("ignored", 3'b010, 0, 0, 3, 1, 1);
    s1("recap",   3'b001, 0, 0, 2, 1, 1);
    s1("trk_nocyc", 3'b100, 0, 0, 0, 1, 1);
    s1("relock",  3'b010, 1, 0, 1, 1, 1);

    // Reset mid-lock with nonzero counters
    l1 = 3'b001; rst = 1'b1; tick(); rst = 1'b0;
    chk_all("rst_lock", 1, 0, 0, 3, 0, 0);
    s1("r_cap",  3'b100, 0, 0, 0, 0, 0);
    s1("r_trk",  3'b010, 0, 0, 1, 0, 0);
    s1("r_lock", 3'b001, 1, 0, 2, 0, 0);
    for (int r = 1; r <= 4; r++) begin
      s1("rot_p0", 3'b100, 1, 0, 0, 0, r);
      s1("rot_p1", 3'b010, 1, 0, 1, 0, r);
      s1("rot_p2", 3'b001, 1, 0, 2, 0, r);
    end
    l1 = 3'b000;

    // Counter saturation at CNT_W=2
    for (int i = 0; i < 5; i++) begin
      s2("s_p0",    3'b100, 0, 0, 0, (i > 3) ? 3 : i, 0);
      s2("s_p1",    3'b010, 0, 0, 1, (i > 3) ? 3 : i, 0);
      s2("s_lock",  3'b001, 1, 0, 2, (i > 3) ? 3 : i, 0);
      s2("s_fault", 3'b010, 0, 1, 3, (i + 1 > 3) ? 3 : i + 1, 0);
      s2("s_ign",   3'b000, 0, 0, 3, (i + 1 > 3) ? 3 : i + 1, 0);
    end
    s2("c_p0",   3'b100, 0, 0, 0, 3, 0);
    s2("c_p1",   3'b010, 0, 0, 1, 3, 0);
    s2("c_lock", 3'b001, 1, 0, 2, 3, 0);
    for (int r = 1; r <= 4; r++) begin
      s2("c_rot0", 3'b100, 1, 0, 0, 3, (r > 3) ? 3 : r);
      s2("c_rot1", 3'b010, 1, 0, 1, 3, (r > 3) ? 3 : r);
      s2("c_rot2", 3'b001, 1, 0, 2, 3, (r > 3) ? 3 : r);
    end
    l2 = 3'b000;

    // DWELL=2: lock, early advance, overlong hold
    s3("d_cap",   3'b100, 0, 0, 0, 0, 0);
    s3("d_hold",  3'b100, 0, 0, 0, 0, 0);
    s3("d_lock",  3'b010, 1, 0, 1, 0, 0);
    s3("d_p1b",   3'b010, 1, 0, 1, 0, 0);
    s3("d_p2a",   3'b001, 1, 0, 2, 0, 0);
    s3("d_p2b",   3'b001, 1, 0, 2, 0, 0);
    s3("d_wrap",  3'b100, 1, 0, 0, 0, 1);
    s3("d_early", 3'b010, 0, 1, 3, 1, 1);
    s3("d_ign",   3'b000, 0, 0, 3, 1, 1);
    s3("d_cap2",  3'b010, 0, 0, 1, 1, 1);
    s3("d_hold2", 3'b010, 0, 0, 1, 1, 1);
    s3("d_lock2", 3'b001, 1, 0, 2, 1, 1);
    s3("d_p2b2",  3'b001, 1, 0, 2, 1, 1);
    s3("d_long",  3'b001, 0, 1, 3, 2, 1);
    l3 = 3'b000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
